// File: rtl/ysyx_22040237_exu_seq.sv
// ysyx_22040237_exu_seq
//   Multi-cycle sequencer between the IDU and the combinational EXU.
//   It accepts one decoded instruction at a time over a valid/ready handshake
//   and holds the operands stable for the EXU. Load/store instructions run a
//   request/acknowledge transaction with the LSU. The register writeback and
//   the PC redirect are then retired in a single-cycle COMMIT pulse.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   id_valid_i / id_ready_o      IDU handshake
//   rd_wr_en_i, rd_idx_i         destination register write enable / index
//   op1_i .. op2_jp_s_i          operands from the IDU
//   exu_info_bus_i               EXU operation info bus from the IDU
//   exu_*_o                      latched operands / info bus driven to the EXU
//   exu_alu_res_i .. exu_jump_addr_i  EXU results sampled in EXEC
//   lsu_req_o .. lsu_info_o      LSU request channel (valid only in MEM)
//   lsu_ack_i, lsu_rdata_i       LSU completion and raw load data
//   wb_en_o, wb_idx_o, wb_data_o register-file write (COMMIT only)
//   redirect_valid_o/_addr_o     PC redirect (COMMIT only)
//   commit_o, lsu_timeout_o      retire pulse, abandoned-access flag
module ysyx_22040237_exu_seq #(
   parameter int LSU_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid_i,
   output logic        id_ready_o,
   input  logic        rd_wr_en_i,
   input  logic [4:0]  rd_idx_i,
   input  logic [63:0] op1_i,
   input  logic [63:0] op2_i,
   input  logic [63:0] op1_jp_i,
   input  logic [63:0] op2_jp_s_i,
   input  logic [15:0] exu_info_bus_i,
   output logic [63:0] exu_op1_o,
   output logic [63:0] exu_op2_o,
   output logic [63:0] exu_op1_jp_o,
   output logic [63:0] exu_op2_jp_s_o,
   output logic [15:0] exu_info_bus_o,
   input  logic [63:0] exu_alu_res_i,
   input  logic [6:0]  exu_ls_info_i,
   input  logic [63:0] exu_rs2_store_i,
   input  logic        exu_jump_flag_i,
   input  logic [63:0] exu_jump_addr_i,
   output logic        lsu_req_o,
   output logic [63:0] lsu_addr_o,
   output logic [63:0] lsu_wdata_o,
   output logic [6:0]  lsu_info_o,
   input  logic        lsu_ack_i,
   input  logic [63:0] lsu_rdata_i,
   output logic        wb_en_o,
   output logic [4:0]  wb_idx_o,
   output logic [63:0] wb_data_o,
   output logic        redirect_valid_o,
   output logic [63:0] redirect_addr_o,
   output logic        commit_o,
   output logic        lsu_timeout_o
);

   typedef enum logic [1:0] {IDLE, EXEC, MEM, COMMIT} state_t;

   localparam logic [7:0] TMO = 8'(LSU_TIMEOUT);

   // ls info bit positions: {dw, word, db, byte, usign, store, load}
   localparam int LS_LOAD  = 0;
   localparam int LS_STORE = 1;
   localparam int LS_USIGN = 2;
   localparam int LS_BYTE  = 3;
   localparam int LS_DB    = 4;
   localparam int LS_WORD  = 5;

   state_t      state, state_nxt;

   logic        rd_wr_en_r;
   logic [4:0]  rd_idx_r;
   logic [63:0] op1_r, op2_r, op1_jp_r, op2_jp_s_r;
   logic [15:0] info_r;
   logic [63:0] alu_res_r, rs2_r, jump_addr_r, rdata_r;
   logic [6:0]  ls_info_r;
   logic        jump_flag_r;
   logic [7:0]  cnt_r;
   logic        timeout_r;

   // Size and sign extension of LSB-aligned load data. A missing size bit
   // falls through to the full doubleword, which also ignores usign.
   function automatic logic [63:0] load_ext(input logic [63:0] d, input logic [6:0] li);
      logic [63:0] r;
      if (li[LS_BYTE])
         r = li[LS_USIGN] ? {56'd0, d[7:0]}  : {{56{d[7]}},  d[7:0]};
      else if (li[LS_DB])
         r = li[LS_USIGN] ? {48'd0, d[15:0]} : {{48{d[15]}}, d[15:0]};
      else if (li[LS_WORD])
         r = li[LS_USIGN] ? {32'd0, d[31:0]} : {{32{d[31]}}, d[31:0]};
      else
         r = d;
      return r;
   endfunction

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (id_valid_i) state_nxt = EXEC;
         EXEC:    state_nxt = (exu_ls_info_i[LS_LOAD] | exu_ls_info_i[LS_STORE]) ? MEM : COMMIT;
         MEM:     if (lsu_ack_i || cnt_r == TMO) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rd_wr_en_r  <= 1'b0;
         rd_idx_r    <= '0;
         op1_r       <= '0;
         op2_r       <= '0;
         op1_jp_r    <= '0;
         op2_jp_s_r  <= '0;
         info_r      <= '0;
         alu_res_r   <= '0;
         rs2_r       <= '0;
         jump_addr_r <= '0;
         rdata_r     <= '0;
         ls_info_r   <= '0;
         jump_flag_r <= 1'b0;
         cnt_r       <= '0;
         timeout_r   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (id_valid_i) begin
                  rd_wr_en_r <= rd_wr_en_i;
                  rd_idx_r   <= rd_idx_i;
                  op1_r      <= op1_i;
                  op2_r      <= op2_i;
                  op1_jp_r   <= op1_jp_i;
                  op2_jp_s_r <= op2_jp_s_i;
                  info_r     <= exu_info_bus_i;
               end
            end
            EXEC: begin
               alu_res_r   <= exu_alu_res_i;
               ls_info_r   <= exu_ls_info_i;
               rs2_r       <= exu_rs2_store_i;
               jump_flag_r <= exu_jump_flag_i;
               jump_addr_r <= exu_jump_addr_i;
               cnt_r       <= '0;
               timeout_r   <= 1'b0;
               // An abandoned load then writes back a defined zero.
               rdata_r     <= '0;
            end
            MEM: begin
               // Ack has priority over the timeout compare in the same cycle.
               if (lsu_ack_i)
                  rdata_r <= lsu_rdata_i;
               else if (cnt_r == TMO)
                  timeout_r <= 1'b1;
               else
                  cnt_r <= cnt_r + 8'd1;
            end
            default: ;
         endcase
      end
   end

   // Every output is forced low while rst is high, so a reset mid-operation
   // drops the request and any pending commit in that very cycle.
   always_comb begin
      id_ready_o       = 1'b0;
      exu_op1_o        = '0;
      exu_op2_o        = '0;
      exu_op1_jp_o     = '0;
      exu_op2_jp_s_o   = '0;
      exu_info_bus_o   = '0;
      lsu_req_o        = 1'b0;
      lsu_addr_o       = '0;
      lsu_wdata_o      = '0;
      lsu_info_o       = '0;
      wb_en_o          = 1'b0;
      wb_idx_o         = '0;
      wb_data_o        = '0;
      redirect_valid_o = 1'b0;
      redirect_addr_o  = '0;
      commit_o         = 1'b0;
      lsu_timeout_o    = 1'b0;
      if (!rst) begin
         exu_op1_o      = op1_r;
         exu_op2_o      = op2_r;
         exu_op1_jp_o   = op1_jp_r;
         exu_op2_jp_s_o = op2_jp_s_r;
         exu_info_bus_o = info_r;
         case (state)
            IDLE: id_ready_o = 1'b1;
            MEM: begin
               lsu_req_o   = 1'b1;
               lsu_addr_o  = alu_res_r;
               lsu_wdata_o = ls_info_r[LS_STORE] ? rs2_r : 64'd0;
               lsu_info_o  = ls_info_r;
            end
            COMMIT: begin
               commit_o         = 1'b1;
               wb_en_o          = rd_wr_en_r & (rd_idx_r != 5'd0) & ~ls_info_r[LS_STORE] & ~timeout_r;
               wb_idx_o         = rd_idx_r;
               wb_data_o        = ls_info_r[LS_LOAD] ? load_ext(rdata_r, ls_info_r) : alu_res_r;
               redirect_valid_o = jump_flag_r;
               redirect_addr_o  = jump_addr_r;
               lsu_timeout_o    = timeout_r;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22040237_exu_seq.sv
// Testbench for ysyx_22040237_exu_seq: directed cases followed by randomized
// transactions, the bench acting as IDU, EXU and LSU, checked against a
// transaction-level reference model.
module tb_ysyx_22040237_exu_seq;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid_i, id_ready_o;
   logic        rd_wr_en_i;
   logic [4:0]  rd_idx_i;
   logic [63:0] op1_i, op2_i, op1_jp_i, op2_jp_s_i;
   logic [15:0] exu_info_bus_i;
   logic [63:0] exu_op1_o, exu_op2_o, exu_op1_jp_o, exu_op2_jp_s_o;
   logic [15:0] exu_info_bus_o;
   logic [63:0] exu_alu_res_i, exu_rs2_store_i, exu_jump_addr_i;
   logic [6:0]  exu_ls_info_i;
   logic        exu_jump_flag_i;
   logic        lsu_req_o;
   logic [63:0] lsu_addr_o, lsu_wdata_o;
   logic [6:0]  lsu_info_o;
   logic        lsu_ack_i;
   logic [63:0] lsu_rdata_i;
   logic        wb_en_o;
   logic [4:0]  wb_idx_o;
   logic [63:0] wb_data_o;
   logic        redirect_valid_o;
   logic [63:0] redirect_addr_o;
   logic        commit_o, lsu_timeout_o;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   ysyx_22040237_exu_seq #(.LSU_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
      .rd_wr_en_i(rd_wr_en_i), .rd_idx_i(rd_idx_i),
      .op1_i(op1_i), .op2_i(op2_i), .op1_jp_i(op1_jp_i), .op2_jp_s_i(op2_jp_s_i),
      .exu_info_bus_i(exu_info_bus_i),
      .exu_op1_o(exu_op1_o), .exu_op2_o(exu_op2_o),
      .exu_op1_jp_o(exu_op1_jp_o), .exu_op2_jp_s_o(exu_op2_jp_s_o),
      .exu_info_bus_o(exu_info_bus_o),
      .exu_alu_res_i(exu_alu_res_i), .exu_ls_info_i(exu_ls_info_i),
      .exu_rs2_store_i(exu_rs2_store_i), .exu_jump_flag_i(exu_jump_flag_i),
      .exu_jump_addr_i(exu_jump_addr_i),
      .lsu_req_o(lsu_req_o), .lsu_addr_o(lsu_addr_o), .lsu_wdata_o(lsu_wdata_o),
      .lsu_info_o(lsu_info_o), .lsu_ack_i(lsu_ack_i), .lsu_rdata_i(lsu_rdata_i),
      .wb_en_o(wb_en_o), .wb_idx_o(wb_idx_o), .wb_data_o(wb_data_o),
      .redirect_valid_o(redirect_valid_o), .redirect_addr_o(redirect_addr_o),
      .commit_o(commit_o), .lsu_timeout_o(lsu_timeout_o)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Reference load extension: keep the low n bits, then either mask or
   // arithmetic-shift them back down to sign-fill.
   function automatic logic [63:0] ref_ext(input logic [63:0] d, input logic [6:0] li);
      int n;
      if (li[3])      n = 8;
      else if (li[4]) n = 16;
      else if (li[5]) n = 32;
      else            n = 64;
      if (n == 64) return d;
      if (li[2])   return d & ((64'd1 << n) - 64'd1);
      return 64'($signed(d << (64 - n)) >>> (64 - n));
   endfunction

   task automatic drive_exu_junk();
      exu_alu_res_i   = rnd64();
      exu_ls_info_i   = 7'($urandom);
      exu_rs2_store_i = rnd64();
      exu_jump_flag_i = 1'($urandom);
      exu_jump_addr_i = rnd64();
   endtask

   // One instruction end to end. k = MEM cycle (0-based) in which the ack is
   // given; k > TMO means the LSU never answers.
   task automatic txn(input logic [6:0] li, input logic wen, input logic [4:0] idx,
                      input logic [63:0] op1, input logic [63:0] op2,
                      input logic [63:0] alu, input logic [63:0] rs2,
                      input logic [63:0] rdata, input logic jf,
                      input logic [63:0] jaddr, input int k, input int gap);
      logic [63:0] o1j, o2j, exp_data;
      logic [15:0] inf;
      logic        is_mem, tmo;
      o1j = rnd64();
      o2j = rnd64();
      inf = 16'($urandom);
      for (int g = 0; g < gap; g++) begin
         chk("gap_ready", id_ready_o, 1);
         tick();
      end
      chk("idle_ready", id_ready_o, 1);
      id_valid_i = 1; rd_wr_en_i = wen; rd_idx_i = idx;
      op1_i = op1; op2_i = op2; op1_jp_i = o1j; op2_jp_s_i = o2j; exu_info_bus_i = inf;
      drive_exu_junk();
      tick();
      // EXEC
      chk("exec_ready", id_ready_o, 0);
      chk("exec_op1", exu_op1_o, op1);
      chk("exec_op2", exu_op2_o, op2);
      chk("exec_op1jp", exu_op1_jp_o, o1j);
      chk("exec_op2jp", exu_op2_jp_s_o, o2j);
      chk("exec_info", 64'(exu_info_bus_o), 64'(inf));
      chk("exec_req", lsu_req_o, 0);
      chk("exec_commit", commit_o, 0);
      id_valid_i = 0; rd_wr_en_i = 1'($urandom); rd_idx_i = 5'($urandom);
      op1_i = rnd64(); op2_i = rnd64();
      exu_alu_res_i = alu; exu_ls_info_i = li; exu_rs2_store_i = rs2;
      exu_jump_flag_i = jf; exu_jump_addr_i = jaddr;
      tick();
      drive_exu_junk();
      is_mem = li[0] | li[1];
      tmo    = is_mem && (k > TMO);
      if (is_mem) begin
         for (int m = 0; m <= TMO; m++) begin
            chk("mem_req", lsu_req_o, 1);
            chk("mem_addr", lsu_addr_o, alu);
            chk("mem_wdata", lsu_wdata_o, li[1] ? rs2 : 64'd0);
            chk("mem_info", 64'(lsu_info_o), 64'(li));
            chk("mem_ready", id_ready_o, 0);
            lsu_ack_i   = (m == k);
            lsu_rdata_i = (m == k) ? rdata : rnd64();
            tick();
            lsu_ack_i   = 0;
            lsu_rdata_i = rnd64();
            if (m == k) break;
         end
      end
      // COMMIT
      exp_data = li[0] ? ref_ext(tmo ? 64'd0 : rdata, li) : alu;
      chk("cmt_commit", commit_o, 1);
      chk("cmt_ready", id_ready_o, 0);
      chk("cmt_req", lsu_req_o, 0);
      chk("cmt_wb_en", wb_en_o, wen && idx != 0 && !li[1] && !tmo);
      chk("cmt_wb_idx", 64'(wb_idx_o), 64'(idx));
      chk("cmt_wb_data", wb_data_o, exp_data);
      chk("cmt_redir_v", redirect_valid_o, jf);
      chk("cmt_redir_a", redirect_addr_o, jaddr);
      chk("cmt_timeout", lsu_timeout_o, tmo);
      chk("cmt_op1_hold", exu_op1_o, op1);
      tick();
      // back in IDLE
      chk("post_ready", id_ready_o, 1);
      chk("post_commit", commit_o, 0);
      chk("post_wb_en", wb_en_o, 0);
      chk("post_wb_data", wb_data_o, 0);
      chk("post_redir_a", redirect_addr_o, 0);
      chk("post_addr", lsu_addr_o, 0);
   endtask

   initial begin
      logic [6:0]  li;
      logic [3:0]  sz;
      rst = 1; id_valid_i = 0; rd_wr_en_i = 0; rd_idx_i = 0;
      op1_i = 0; op2_i = 0; op1_jp_i = 0; op2_jp_s_i = 0; exu_info_bus_i = 0;
      exu_alu_res_i = 0; exu_ls_info_i = 0; exu_rs2_store_i = 0;
      exu_jump_flag_i = 0; exu_jump_addr_i = 0; lsu_ack_i = 0; lsu_rdata_i = 0;
      repeat (3) tick();
      chk("rst_ready", id_ready_o, 0);
      chk("rst_req", lsu_req_o, 0);
      chk("rst_commit", commit_o, 0);
      chk("rst_op1", exu_op1_o, 0);
      rst = 0;
      #1;
      chk("rst_rel_ready", id_ready_o, 1);

      // ALU add, lb/lbu/lw, sd, taken branch, jal rd=0, timeout, coincident ack
      txn(7'b0000000, 1, 5, 64'd5, 64'd7, 64'd12, 64'd0, 64'd0, 0, 64'd0, 0, 0);
      txn(7'b0001001, 1, 3, rnd64(), rnd64(), 64'h80000020, 64'd0, 64'h80, 0, 64'd0, 2, 0);
      txn(7'b0001101, 1, 3, rnd64(), rnd64(), 64'h80000020, 64'd0, 64'h80, 0, 64'd0, 2, 0);
      txn(7'b0100001, 1, 9, rnd64(), rnd64(), 64'h80000040, 64'd0, 64'h80000000, 0, 64'd0, 1, 0);
      txn(7'b1000010, 1, 4, rnd64(), rnd64(), 64'h80000010, 64'hDEADBEEF, 64'd0, 0, 64'd0, 0, 0);
      txn(7'b0000000, 0, 0, rnd64(), rnd64(), rnd64(), 64'd0, 64'd0, 1, 64'h80000100, 0, 0);
      txn(7'b0000000, 1, 0, rnd64(), rnd64(), 64'h80000004, 64'd0, 64'd0, 1, 64'h80000200, 0, 0);
      txn(7'b1000001, 1, 7, rnd64(), rnd64(), 64'h80000080, 64'd0, rnd64(), 0, 64'd0, 99, 0);
      txn(7'b1000001, 1, 7, rnd64(), rnd64(), 64'h80000088, 64'd0, 64'h1234, 0, 64'd0, TMO, 0);

      // reset pulsed in the second MEM cycle
      id_valid_i = 1; rd_wr_en_i = 1; rd_idx_i = 6; op1_i = rnd64(); op2_i = rnd64();
      tick();
      id_valid_i = 0; exu_ls_info_i = 7'b1000001; exu_alu_res_i = 64'h80000300;
      tick();
      drive_exu_junk();
      chk("rmem_req1", lsu_req_o, 1);
      tick();
      rst = 1;
      #1;
      chk("rmem_req2", lsu_req_o, 0);
      chk("rmem_commit", commit_o, 0);
      chk("rmem_ready", id_ready_o, 0);
      tick();
      rst = 0;
      #1;
      chk("rmem_rel_ready", id_ready_o, 1);
      chk("rmem_op1_clr", exu_op1_o, 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rmem_no_commit", commit_o, 0);
      end

      // randomized traffic
      for (int t = 0; t < 150; t++) begin
         case ($urandom_range(0, 3))
            0: li = 7'b0000000;
            1, 2: begin
               sz = 4'd0;
               if ($urandom_range(0, 4) != 0) sz[$urandom_range(0, 3)] = 1'b1;
               li = {sz[3], sz[2], sz[1], sz[0], 1'($urandom), 2'b01};
            end
            default: begin
               sz = 4'd0;
               sz[$urandom_range(0, 3)] = 1'b1;
               li = {sz, 1'b0, 2'b10};
            end
         endcase
         txn(li, 1'($urandom), 5'($urandom), rnd64(), rnd64(), rnd64(), rnd64(),
             rnd64(), 1'($urandom), rnd64(), $urandom_range(0, 6), $urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ysyx_22040237_exu_seq.md
# ysyx_22040237_exu_seq

Multi-cycle sequencer that sits between the IDU and the combinational EXU. It accepts one decoded instruction at a time over a valid/ready handshake and holds its operands stable for the EXU. For load/store it runs a request/acknowledge transaction with the LSU and sign- or zero-extends load data. It then commits the register writeback and the PC redirect in a single-cycle pulse.

## Interface

Parameters:
- LSU_TIMEOUT, 255: maximum cycles in MEM without `lsu_ack_i` before the access is abandoned (range 1..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid_i  in  1  IDU holds a decoded instruction.
- id_ready_o  out  1  sequencer can accept an instruction.
- rd_wr_en_i, rd_idx_i  in  1, 5  destination register write enable and index.
- op1_i, op2_i, op1_jp_i, op2_jp_s_i  in  64 each  operands from IDU.
- exu_info_bus_i  in  16  EXU operation info bus.
- exu_op1_o, exu_op2_o, exu_op1_jp_o, exu_op2_jp_s_o  out  64 each  latched operands driven to EXU.
- exu_info_bus_o  out  16  latched info bus to EXU.
- exu_alu_res_i  in  64  EXU result (the effective address for load/store).
- exu_ls_info_i  in  7  {dw, word, db, byte, usign, store, load}.
- exu_rs2_store_i  in  64  store data.
- exu_jump_flag_i  in  1  EXU jump decision.
- exu_jump_addr_i  in  64  EXU jump target.
- lsu_req_o  out  1  memory request.
- lsu_addr_o  out  64  memory address.
- lsu_wdata_o  out  64  store data.
- lsu_info_o  out  7  copy of the captured ls info.
- lsu_ack_i  in  1  LSU completion.
- lsu_rdata_i  in  64  raw load data, LSB-aligned.
- wb_en_o, wb_idx_o, wb_data_o  out  1, 5, 64  register-file write.
- redirect_valid_o, redirect_addr_o  out  1, 64  PC redirect.
- commit_o  out  1  instruction retired.
- lsu_timeout_o  out  1  abandoned memory access.

## Operation

States: IDLE, EXEC, MEM, COMMIT.

- **IDLE**
  - `id_ready_o = 1`.
  - On `id_valid_i`, latch rd_wr_en, rd_idx, the four operands and the info bus, then go to EXEC.
  - Without `id_valid_i`, stay in IDLE.
- **EXEC** (exactly 1 cycle)
  - The EXU evaluates the latched inputs.
  - Capture `exu_alu_res_i`, `exu_ls_info_i`, `exu_rs2_store_i`, `exu_jump_flag_i` and `exu_jump_addr_i`.
  - If ls_info[0] (load) or ls_info[1] (store) is set, go to MEM and clear the timeout counter. Otherwise go to COMMIT.
- **MEM**
  - Drive `lsu_req_o = 1`, `lsu_addr_o` = captured alu_res, `lsu_wdata_o` = captured rs2 when store else 0, and `lsu_info_o` = captured ls info. Hold all of these until the ack.
  - `lsu_ack_i` is sampled in every MEM cycle, including the first.
  - On ack: capture `lsu_rdata_i`, go to COMMIT.
  - Otherwise increment the 8-bit counter.
  - When the counter equals LSU_TIMEOUT with no ack: set the timeout flag, go to COMMIT.
  - An ack in the same cycle the counter reaches LSU_TIMEOUT wins: normal completion, no timeout.
- **COMMIT** (exactly 1 cycle), then go to IDLE
  - `commit_o = 1`.
  - `wb_en_o = rd_wr_en & (rd_idx != 0) & !store & !timeout`.
  - `wb_data_o` = extended load data for a load, else the captured alu_res.
  - `redirect_valid_o` = captured jump flag; `redirect_addr_o` = captured jump addr.
  - `lsu_timeout_o` = timeout flag.
- **Load extension**
  - Size selected by byte = 8 bits, db = 16, word = 32, dw = 64 bits of `lsu_rdata_i`.
  - usign = 1 zero-extends; otherwise sign-extend from the top bit of the selected field.
  - dw ignores usign.
  - If no size bit is set, treat as dw.

## Timing

- **Reset**
  - `rst = 1` forces the state to IDLE and clears the counter and every captured register.
  - All outputs are 0 while reset is asserted, including `id_ready_o` and `lsu_req_o`.
  - `id_ready_o = 1` from the first cycle after `rst` deasserts.
- **Reset mid-operation** (EXEC, MEM or COMMIT)
  - The instruction is dropped; no `commit_o` and no wb or redirect.
  - `lsu_req_o` is 0 from the cycle `rst` is high.
- **Latency**
  - Accept at cycle T, then EXEC at T+1.
  - Non-memory instructions: COMMIT at T+2.
  - Memory instructions: MEM from T+2; ack at cycle T+2+k gives COMMIT at T+3+k.
  - Timeout: COMMIT at T+3+LSU_TIMEOUT.
- **Throughput**
  - The next accept is possible at the cycle after COMMIT, so back-to-back ALU operations take 3 cycles each.
  - `id_ready_o` is 0 in EXEC, MEM and COMMIT.
- **Pulses and holds**
  - `commit_o`, `wb_en_o`, `redirect_valid_o` and `lsu_timeout_o` are high only in COMMIT; `wb_idx_o`, `wb_data_o` and `redirect_addr_o` are 0 outside COMMIT.
  - `exu_*_o` hold the latched values from accept until the next accept.
  - `lsu_addr_o`, `lsu_wdata_o` and `lsu_info_o` are 0 outside MEM.

## Test plan

- **ALU add**: addi rd=5, op1=5, op2=7, accepted at T -> COMMIT at T+2 with `wb_en_o = 1`, `wb_idx_o = 5`, `wb_data_o = 12`, `redirect_valid_o = 0`; `id_ready_o` 0 at T+1 and T+2, 1 at T+3.
- **Signed and unsigned byte load**:
  - lb rd=3, ack after 2 wait cycles, rdata = 0x80 -> `wb_data_o = 0xFFFFFFFFFFFFFF80`, COMMIT at T+5.
  - Same with lbu -> 0x0000000000000080.
  - lw with rdata 0x00000000_80000000 -> 0xFFFFFFFF80000000.
- **Store**: sd addr 0x80000010, rs2 = 0xDEADBEEF, ack in the first MEM cycle -> `lsu_req_o` high for exactly 1 cycle with that addr and wdata; COMMIT with `wb_en_o = 0`.
- **Taken branch and rd=0**:
  - Taken branch with jump addr 0x80000100 -> `redirect_valid_o = 1`, `redirect_addr_o = 0x80000100` in COMMIT.
  - jal with rd=0 -> `wb_en_o = 0`, redirect asserted.
- **Timeout**:
  - LSU_TIMEOUT = 4, no ack -> `lsu_req_o` high for 5 cycles, then COMMIT with `lsu_timeout_o = 1`, `wb_en_o = 0`.
  - Ack coincident with the counter reaching 4 -> normal completion, `lsu_timeout_o = 0`.
- **Reset in MEM**: `rst` pulsed on the 2nd MEM cycle -> `lsu_req_o = 0` that cycle, no `commit_o`, `id_ready_o = 1` on the cycle after `rst` falls.
